// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
package regfile_arb_pkg;

  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_1    = 2'd1,
    PORT_2    = 2'd2
  } rd_port_t;

endpackage

// File: rtl/rf_arb_rotate.sv
// Index rotation for round-robin scanning.
// Forward path: slot k of fwd_out carries requester (ptr + k) mod N, so the
// scan can always start at slot 0. Back path undoes the mapping so results
// computed per slot land on the requester they belong to.
module rf_arb_rotate #(
  parameter int N  = 4,
  parameter int FW = 1,
  parameter int BW = 1,
  parameter int PW = 2
) (
  input  logic [PW-1:0]   ptr,
  input  logic [N*FW-1:0] fwd_in,
  output logic [N*FW-1:0] fwd_out,
  input  logic [N*BW-1:0] back_in,
  output logic [N*BW-1:0] back_out
);

  // Requester (ptr + k) mod N moves into scan slot k
  always_comb begin
    int src;
    src     = 0;
    fwd_out = '0;
    for (int k = 0; k < N; k++) begin
      src = (k + int'(ptr)) % N;
      fwd_out[k*FW +: FW] = fwd_in[src*FW +: FW];
    end
  end

  // Scan slot (i - ptr) mod N returns to requester i
  always_comb begin
    int src;
    src      = 0;
    back_out = '0;
    for (int i = 0; i < N; i++) begin
      src = (i - int'(ptr) + N) % N;
      back_out[i*BW +: BW] = back_in[src*BW +: BW];
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one register file (1 write, 2 read ports)
// among NUM_REQ requesters. Grants at most one write and two reads per
// cycle and never issues a combination the regfile would flag as a
// collision. Read data returns one cycle after the grant.
// Optional build macro REGFILE_ARB_READ_MERGE_EN: a read to the same address
// as an already-granted read shares that port instead of waiting a cycle.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata,
  output logic                          rf_wen1,
  output logic [ADDR_W-1:0]             rf_wad1,
  output logic [DATA_WIDTH-1:0]         rf_din,
  output logic                          rf_ren1,
  output logic [ADDR_W-1:0]             rf_rad1,
  output logic                          rf_ren2,
  output logic [ADDR_W-1:0]             rf_rad2,
  input  logic [DATA_WIDTH-1:0]         rf_dout1,
  input  logic [DATA_WIDTH-1:0]         rf_dout2,
  input  logic                          rf_collision,
  input  logic                          halt_req,
  output logic                          halt_ack,
  output logic                          err_collision
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int FW    = 2 + ADDR_W + DATA_WIDTH;
  localparam int BW    = 3;

  arb_state_t state_q, state_d;

  logic [PTR_W-1:0]        rr_ptr, rr_next;
  logic                    scan_en, any_gnt;
  logic [NUM_REQ*FW-1:0]   fwd_in, fwd_rot;
  logic [NUM_REQ*BW-1:0]   back_rot, back_out;
  logic [NUM_REQ-1:0]      gnt_rot;
  rd_port_t                port_rot [NUM_REQ];
  rd_port_t                port_sel [NUM_REQ];
  rd_port_t                sel_q    [NUM_REQ];
  logic [NUM_REQ-1:0]      pend_q, pend_live;
  logic [DATA_WIDTH-1:0]   hold_q   [NUM_REQ];
  logic [DATA_WIDTH-1:0]   rsp_mux  [NUM_REQ];

  // Grants only happen while running, not halting, and out of reset
  assign scan_en = resetn && (state_q == RUN) && !halt_req;

  // Bundle each requester's request fields into one slot for the rotator
  always_comb begin
    fwd_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fwd_in[i*FW +: FW] = {req_valid[i], req_we[i],
                            req_addr[i*ADDR_W +: ADDR_W],
                            req_wdata[i*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  rf_arb_rotate #(
    .N  (NUM_REQ),
    .FW (FW),
    .BW (BW),
    .PW (PTR_W)
  ) u_rotate (
    .ptr      (rr_ptr),
    .fwd_in   (fwd_in),
    .fwd_out  (fwd_rot),
    .back_in  (back_rot),
    .back_out (back_out)
  );

  // Scan slots in round-robin order, granting ports without collisions
  always_comb begin
    logic                  s_valid, s_we, hit1, hit2, wr_done, new_ok;
    logic [ADDR_W-1:0]     s_addr, wr_addr, rd_addr1, rd_addr2;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic [1:0]            rd_cnt;
    int                    last_k;
    s_valid  = 1'b0;
    s_we     = 1'b0;
    hit1     = 1'b0;
    hit2     = 1'b0;
    wr_done  = 1'b0;
    new_ok   = 1'b0;
    s_addr   = '0;
    wr_addr  = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    s_wdata  = '0;
    rd_cnt   = 2'd0;
    last_k   = 0;
    gnt_rot  = '0;
    rf_wen1  = 1'b0;
    rf_wad1  = '0;
    rf_din   = '0;
    rf_ren1  = 1'b0;
    rf_rad1  = '0;
    rf_ren2  = 1'b0;
    rf_rad2  = '0;
    for (int k = 0; k < NUM_REQ; k++) port_rot[k] = PORT_NONE;
    if (scan_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        {s_valid, s_we, s_addr, s_wdata} = fwd_rot[k*FW +: FW];
        hit1 = (rd_cnt != 2'd0) && (s_addr == rd_addr1);
        hit2 = (rd_cnt == 2'd2) && (s_addr == rd_addr2);
        if (s_valid && s_we) begin
          if (!wr_done && !hit1 && !hit2) begin
            wr_done    = 1'b1;
            wr_addr    = s_addr;
            rf_wen1    = 1'b1;
            rf_wad1    = s_addr;
            rf_din     = s_wdata;
            gnt_rot[k] = 1'b1;
            last_k     = k;
          end
        end else if (s_valid && !(wr_done && (s_addr == wr_addr))) begin
`ifdef REGFILE_ARB_READ_MERGE_EN
          if (hit1) begin
            gnt_rot[k]  = 1'b1;
            port_rot[k] = PORT_1;
            last_k      = k;
          end else if (hit2) begin
            gnt_rot[k]  = 1'b1;
            port_rot[k] = PORT_2;
            last_k      = k;
          end
`endif
          new_ok = !hit1 && !hit2 && (rd_cnt != 2'd2);
          if (new_ok) begin
            if (rd_cnt == 2'd0) begin
              rf_ren1     = 1'b1;
              rf_rad1     = s_addr;
              rd_addr1    = s_addr;
              port_rot[k] = PORT_1;
            end else begin
              rf_ren2     = 1'b1;
              rf_rad2     = s_addr;
              rd_addr2    = s_addr;
              port_rot[k] = PORT_2;
            end
            rd_cnt     = rd_cnt + 2'd1;
            gnt_rot[k] = 1'b1;
            last_k     = k;
          end
        end
      end
    end
    any_gnt = |gnt_rot;
    rr_next = PTR_W'((int'(rr_ptr) + last_k + 1) % NUM_REQ);
  end

  // Pack per-slot grant results for the return trip through the rotator
  always_comb begin
    back_rot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      back_rot[k*BW +: BW] = {gnt_rot[k], port_rot[k]};
    end
  end

  // Unpack grant and read-port selection per requester
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = back_out[i*BW + 2];
      port_sel[i]  = rd_port_t'(back_out[i*BW +: 2]);
    end
  end

  // Next scan starts just past the last requester granted
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (any_gnt) begin
      rr_ptr <= rr_next;
    end
  end

  // Remember which requesters expect read data next cycle and from which port
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) sel_q[i] <= PORT_NONE;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        pend_q[i] <= req_ready[i] && (port_sel[i] != PORT_NONE);
        sel_q[i]  <= port_sel[i];
      end
    end
  end

  // A response in flight when reset asserts is dropped immediately
  assign pend_live = pend_q & {NUM_REQ{resetn}};

  // Route the regfile's registered read data to each waiting requester
  always_comb begin
    rsp_rdata = '0;
    rsp_valid = pend_live;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_mux[i] = (sel_q[i] == PORT_2) ? rf_dout2 : rf_dout1;
      rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = pend_live[i] ? rsp_mux[i] : hold_q[i];
    end
  end

  // Keep the last delivered data visible between responses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REQ; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pend_q[i]) hold_q[i] <= rsp_mux[i];
      end
    end
  end

  // Run-state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Halt sequencing: stop granting, let responses finish, then acknowledge
  always_comb begin
    state_d  = state_q;
    halt_ack = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (pend_q == '0) state_d = HALT;
      end
      HALT: begin
        halt_ack = 1'b1;
        if (!halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Sticky record of any collision the regfile reports
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_collision <= 1'b0;
    end else if (rf_collision) begin
      err_collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter with a behavioural regfile
// and a scan-order reference model of the arbitration rules.
module tb_regfile_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rsp_rdata;
  logic          rf_wen1, rf_ren1, rf_ren2;
  logic [AW-1:0] rf_wad1, rf_rad1, rf_rad2;
  logic [DW-1:0] rf_din, rf_dout1, rf_dout2;
  logic          rf_collision;
  logic          halt_req, halt_ack, err_collision;
  logic          force_coll;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rf_wen1(rf_wen1), .rf_wad1(rf_wad1), .rf_din(rf_din),
    .rf_ren1(rf_ren1), .rf_rad1(rf_rad1), .rf_ren2(rf_ren2), .rf_rad2(rf_rad2),
    .rf_dout1(rf_dout1), .rf_dout2(rf_dout2), .rf_collision(rf_collision),
    .halt_req(halt_req), .halt_ack(halt_ack), .err_collision(err_collision)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 'h0123) ^ 16'h5A5A;
  endfunction

  // Behavioural regfile: registered reads, collision flag registered
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int a = 0; a < 32; a++) rf_mem[a] <= init_val(a);
      rf_dout1     <= '0;
      rf_dout2     <= '0;
      rf_collision <= 1'b0;
    end else begin
      if (rf_ren1) rf_dout1 <= rf_mem[rf_rad1];
      if (rf_ren2) rf_dout2 <= rf_mem[rf_rad2];
      if (rf_wen1) rf_mem[rf_wad1] <= rf_din;
      rf_collision <= force_coll
                    | (rf_wen1 && ((rf_ren1 && rf_rad1 == rf_wad1) || (rf_ren2 && rf_rad2 == rf_wad1)))
                    | (rf_ren1 && rf_ren2 && rf_rad1 == rf_rad2);
    end
  end

  // Stimulus arrays and reference model state
  bit            r_valid [N];
  bit            r_we    [N];
  logic [AW-1:0] r_addr  [N];
  logic [DW-1:0] r_wdata [N];

  logic [DW-1:0] m_mem   [32];
  int            m_ptr;
  bit            m_pend  [N];
  logic [DW-1:0] m_pdata [N];
  logic [DW-1:0] m_hold  [N];

  logic [N-1:0]  e_ready;
  logic          e_wen, e_ren1, e_ren2;
  logic [AW-1:0] e_wad, e_rad1, e_rad2;
  logic [DW-1:0] e_din;
  int            e_next;

  function automatic void apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = r_valid[i];
      req_we[i]    = r_we[i];
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wdata[i*DW +: DW] = r_wdata[i];
    end
  endfunction

  function automatic void set_req(input int i, input bit v, input bit we,
                                  input logic [AW-1:0] a, input logic [DW-1:0] d);
    r_valid[i] = v; r_we[i] = we; r_addr[i] = a; r_wdata[i] = d;
    apply();
  endfunction

  function automatic void clear_req();
    for (int i = 0; i < N; i++) begin
      r_valid[i] = 0; r_we[i] = 0; r_addr[i] = '0; r_wdata[i] = '0;
    end
    apply();
  endfunction

  // Expected grants: walk requesters from the pointer, tracking granted addresses
  function automatic void model_comb();
    int nrd;
    bit wdone;
    bit same;
    int i;
    logic [AW-1:0] radr [2];
    e_ready = '0; e_wen = 0; e_wad = '0; e_din = '0;
    e_ren1 = 0; e_rad1 = '0; e_ren2 = 0; e_rad2 = '0;
    e_next = m_ptr; nrd = 0; wdone = 0;
    radr[0] = '0; radr[1] = '0;
    for (int s = 0; s < N; s++) begin
      i = (m_ptr + s) % N;
      if (!r_valid[i]) continue;
      same = (nrd > 0 && radr[0] == r_addr[i]) || (nrd > 1 && radr[1] == r_addr[i]);
      if (r_we[i]) begin
        if (!wdone && !same) begin
          wdone = 1; e_wen = 1; e_wad = r_addr[i]; e_din = r_wdata[i];
          e_ready[i] = 1'b1; e_next = (i + 1) % N;
        end
      end else begin
        if (wdone && e_wad == r_addr[i]) continue;
        if (same) begin
`ifdef REGFILE_ARB_READ_MERGE_EN
          e_ready[i] = 1'b1; e_next = (i + 1) % N;
`endif
        end else if (nrd < 2) begin
          radr[nrd] = r_addr[i];
          if (nrd == 0) begin e_ren1 = 1; e_rad1 = r_addr[i]; end
          else begin e_ren2 = 1; e_rad2 = r_addr[i]; end
          nrd++;
          e_ready[i] = 1'b1; e_next = (i + 1) % N;
        end
      end
    end
  endfunction

  // Advance the model across a clock edge
  function automatic void model_commit();
    for (int i = 0; i < N; i++) begin
      if (m_pend[i]) m_hold[i] = m_pdata[i];
      m_pend[i] = e_ready[i] && !r_we[i];
      if (m_pend[i]) m_pdata[i] = m_mem[r_addr[i]];
    end
    if (e_wen) m_mem[e_wad] = e_din;
    if (e_ready != '0) m_ptr = e_next;
  endfunction

  task automatic do_reset();
    resetn = 1'b0; halt_req = 1'b0; force_coll = 1'b0;
    clear_req();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    m_ptr = 0;
    for (int a = 0; a < 32; a++) m_mem[a] = init_val(a);
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_pdata[i] = '0; m_hold[i] = '0; end
  endtask

  task automatic test_reset();
    resetn = 1'b0; halt_req = 1'b0; force_coll = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1, i[0], AW'(i + 1), DW'(i));
    @(posedge clk); @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if ({rf_wen1, rf_ren1, rf_ren2} !== 3'b000) begin errors++; $display("FAIL reset_enables got %b want 000", {rf_wen1, rf_ren1, rf_ren2}); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    @(posedge clk); @(negedge clk);
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    checks++; if ({halt_ack, err_collision} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {halt_ack, err_collision}); end
    do_reset();
  endtask

  task automatic test_reads();
    do_reset();
    set_req(0, 1, 0, 5'd3, '0); set_req(1, 1, 0, 5'd7, '0); set_req(2, 1, 0, 5'd9, '0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL reads_ready0 got %b want 0011", req_ready); end
    checks++; if ({rf_ren1, rf_rad1, rf_ren2, rf_rad2, rf_wen1} !== {1'b1, 5'd3, 1'b1, 5'd7, 1'b0}) begin
      errors++; $display("FAIL reads_ports got %b/%0d %b/%0d want 1/3 1/7", rf_ren1, rf_rad1, rf_ren2, rf_rad2); end
    @(posedge clk); #1; set_req(0, 0, 0, '0, '0); set_req(1, 0, 0, '0, '0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100 || rf_rad1 !== 5'd9) begin errors++; $display("FAIL reads_ready1 got %b rad1 %0d want 0100 rad1 9", req_ready, rf_rad1); end
    checks++; if (rsp_valid !== 4'b0011) begin errors++; $display("FAIL reads_rsp_valid got %b want 0011", rsp_valid); end
    checks++; if (rsp_rdata[0 +: DW] !== init_val(3) || rsp_rdata[DW +: DW] !== init_val(7)) begin
      errors++; $display("FAIL reads_rsp_data got %h %h want %h %h", rsp_rdata[0 +: DW], rsp_rdata[DW +: DW], init_val(3), init_val(7)); end
    @(posedge clk); #1; clear_req();
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0100 || rsp_rdata[2*DW +: DW] !== init_val(9)) begin
      errors++; $display("FAIL reads_r2 got %b %h want 0100 %h", rsp_valid, rsp_rdata[2*DW +: DW], init_val(9)); end
    checks++; if (rsp_rdata[0 +: DW] !== init_val(3)) begin errors++; $display("FAIL reads_hold got %h want %h", rsp_rdata[0 +: DW], init_val(3)); end
  endtask

  task automatic test_write_read();
    do_reset();
    set_req(0, 1, 1, 5'd5, 16'hABCD); set_req(1, 1, 0, 5'd5, '0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wr_ready0 got %b want 0001", req_ready); end
    checks++; if ({rf_wen1, rf_wad1, rf_din, rf_ren1} !== {1'b1, 5'd5, 16'hABCD, 1'b0}) begin
      errors++; $display("FAIL wr_port got %b/%0d/%h ren1 %b want 1/5/abcd 0", rf_wen1, rf_wad1, rf_din, rf_ren1); end
    @(posedge clk); #1; set_req(0, 0, 0, '0, '0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010 || rf_rad1 !== 5'd5) begin errors++; $display("FAIL wr_ready1 got %b rad1 %0d want 0010 5", req_ready, rf_rad1); end
    @(posedge clk); #1; clear_req();
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0010 || rsp_rdata[DW +: DW] !== 16'hABCD) begin
      errors++; $display("FAIL wr_rsp got %b %h want 0010 abcd", rsp_valid, rsp_rdata[DW +: DW]); end
  endtask

  task automatic test_same_addr();
    do_reset();
    set_req(0, 1, 0, 5'd4, '0); set_req(1, 1, 0, 5'd4, '0);
    @(negedge clk);
`ifdef REGFILE_ARB_READ_MERGE_EN
    checks++; if (req_ready !== 4'b0011 || rf_ren2 !== 1'b0) begin errors++; $display("FAIL merge_ready got %b ren2 %b want 0011 0", req_ready, rf_ren2); end
    @(posedge clk); #1; clear_req();
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0011 || rsp_rdata[0 +: DW] !== init_val(4) || rsp_rdata[DW +: DW] !== init_val(4)) begin
      errors++; $display("FAIL merge_rsp got %b %h %h want 0011 %h", rsp_valid, rsp_rdata[0 +: DW], rsp_rdata[DW +: DW], init_val(4)); end
`else
    checks++; if (req_ready !== 4'b0001 || rf_ren2 !== 1'b0) begin errors++; $display("FAIL same_ready0 got %b ren2 %b want 0001 0", req_ready, rf_ren2); end
    @(posedge clk); #1; set_req(0, 0, 0, '0, '0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL same_ready1 got %b want 0010", req_ready); end
    @(posedge clk); #1; clear_req();
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0010 || rsp_rdata[DW +: DW] !== init_val(4)) begin
      errors++; $display("FAIL same_rsp got %b %h want 0010 %h", rsp_valid, rsp_rdata[DW +: DW], init_val(4)); end
`endif
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 1, AW'(16 + i), DW'(16'h1000 + i));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'(1 << (c % 4)) || rf_wad1 !== AW'(16 + c % 4)) begin
        errors++; $display("FAIL rotate_c%0d got %b wad %0d want %b %0d", c, req_ready, rf_wad1, 4'(1 << (c % 4)), 16 + c % 4); end
      @(posedge clk); #1;
    end
    clear_req();
  endtask

  task automatic test_halt();
    do_reset();
    set_req(0, 1, 0, 5'd2, '0); set_req(1, 1, 0, 5'd6, '0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL halt_pre got %b want 0011", req_ready); end
    @(posedge clk); #1 halt_req = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000 || rf_ren1 !== 1'b0 || halt_ack !== 1'b0) begin
      errors++; $display("FAIL halt_req_cycle got %b ren1 %b ack %b want 0000 0 0", req_ready, rf_ren1, halt_ack); end
    checks++; if (rsp_valid !== 4'b0011 || rsp_rdata[0 +: DW] !== init_val(2) || rsp_rdata[DW +: DW] !== init_val(6)) begin
      errors++; $display("FAIL halt_rsp got %b %h %h want 0011", rsp_valid, rsp_rdata[0 +: DW], rsp_rdata[DW +: DW]); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000 || halt_ack !== 1'b0 || rsp_valid !== 4'b0000) begin
      errors++; $display("FAIL halt_drain got %b ack %b rv %b want 0000 0 0000", req_ready, halt_ack, rsp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (halt_ack !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL halt_ack got %b ready %b want 1 0000", halt_ack, req_ready); end
    @(posedge clk); #1 halt_req = 1'b0;
    @(negedge clk);
    checks++; if (halt_ack !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL halt_release got %b ready %b want 1 0000", halt_ack, req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (halt_ack !== 1'b0 || req_ready !== 4'b0011) begin errors++; $display("FAIL halt_resume got %b ready %b want 0 0011", halt_ack, req_ready); end
    @(posedge clk); #1 halt_req = 1'b1;
    @(posedge clk); #1 halt_req = 1'b0;
    @(negedge clk);
    checks++; if (halt_ack !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL drop_drain got %b ready %b want 0 0000", halt_ack, req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (halt_ack !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL drop_halt got %b ready %b want 1 0000", halt_ack, req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (halt_ack !== 1'b0 || req_ready === 4'b0000) begin errors++; $display("FAIL drop_run got %b ready %b want 0 nonzero", halt_ack, req_ready); end
    @(posedge clk); #1 clear_req();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1, 0, 5'd12, '0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_grant got %b want 0001", req_ready); end
    @(posedge clk); #1 resetn = 1'b0; clear_req();
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rmid_during got %b want 0000", rsp_valid); end
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0000 || rsp_rdata[0 +: DW] !== '0) begin
      errors++; $display("FAIL rmid_after got %b %h want 0000 0", rsp_valid, rsp_rdata[0 +: DW]); end
    do_reset();
  endtask

  task automatic test_random();
    logic [N-1:0]    exp_rv;
    logic [N*DW-1:0] exp_rd;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        r_valid[i] = ($urandom_range(0, 3) != 0);
        r_we[i]    = ($urandom_range(0, 2) == 0);
        r_addr[i]  = AW'($urandom_range(0, 7));
        r_wdata[i] = DW'($urandom);
      end
      apply();
      @(negedge clk);
      model_comb();
      for (int i = 0; i < N; i++) begin
        exp_rv[i] = m_pend[i];
        exp_rd[i*DW +: DW] = m_pend[i] ? m_pdata[i] : m_hold[i];
      end
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rand_ready c%0d got %b want %b", c, req_ready, e_ready); end
      checks++; if ({rf_wen1, rf_wad1, rf_din} !== {e_wen, e_wad, e_din}) begin
        errors++; $display("FAIL rand_wport c%0d got %b/%0d/%h want %b/%0d/%h", c, rf_wen1, rf_wad1, rf_din, e_wen, e_wad, e_din); end
      checks++; if ({rf_ren1, rf_rad1, rf_ren2, rf_rad2} !== {e_ren1, e_rad1, e_ren2, e_rad2}) begin
        errors++; $display("FAIL rand_rport c%0d got %b/%0d %b/%0d want %b/%0d %b/%0d", c, rf_ren1, rf_rad1, rf_ren2, rf_rad2, e_ren1, e_rad1, e_ren2, e_rad2); end
      checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rand_rsp_valid c%0d got %b want %b", c, rsp_valid, exp_rv); end
      checks++; if (rsp_rdata !== exp_rd) begin errors++; $display("FAIL rand_rsp_data c%0d got %h want %h", c, rsp_rdata, exp_rd); end
      model_commit();
      @(posedge clk); #1;
    end
    clear_req();
    @(posedge clk); @(negedge clk);
    checks++; if (err_collision !== 1'b0) begin errors++; $display("FAIL rand_no_collision got %b want 0", err_collision); end
  endtask

  task automatic test_collision();
    do_reset();
    @(negedge clk);
    checks++; if (err_collision !== 1'b0) begin errors++; $display("FAIL coll_idle got %b want 0", err_collision); end
    @(posedge clk); #1 force_coll = 1'b1;
    @(posedge clk); #1 force_coll = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (err_collision !== 1'b1) begin errors++; $display("FAIL coll_set got %b want 1", err_collision); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (err_collision !== 1'b1) begin errors++; $display("FAIL coll_sticky got %b want 1", err_collision); end
    do_reset();
    @(negedge clk);
    checks++; if (err_collision !== 1'b0) begin errors++; $display("FAIL coll_clear got %b want 0", err_collision); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; halt_req = 1'b0; force_coll = 1'b0;
    clear_req();
    test_reset();
    test_reads();
    test_write_read();
    test_same_addr();
    test_rotation();
    test_halt();
    test_reset_mid();
    test_random();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
